rf_dbg_arb: RTL and testbench
=============================

Name: rf_dbg_arb

Overview:
- Arbitrates the register file's single write port and its rs read port between the CPU pipeline and the debug monitor.
- On a debug request, halts the CPU and waits a fixed drain period for in-flight writebacks to retire.
- Then performs one debug register read or write and acknowledges it.
- Sits between the pipeline writeback/decode stages and the register file.

Parameters:
- W_DATA, 32, register/data width
- W_RFADDR, 5, register address width
- DRAIN_CYCLES, 3, cycles the CPU is halted before a debug access (0..15)

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- dbg_req  in  1  debug request level; held until dbg_ack
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  W_RFADDR  debug register address
- dbg_wdata  in  W_DATA  debug write data
- dbg_hold  in  1  keep CPU halted after the access completes
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  W_DATA  read result, held until the next read
- dbg_err  out  1  sticky: pipeline wrote while halted
- cpu_halt  out  1  stall request to the fetch/pipeline
- cpu_wb_we  in  1  pipeline writeback enable
- cpu_wb_addr  in  W_RFADDR  pipeline writeback register
- cpu_wb_data  in  W_DATA  pipeline writeback data
- cpu_rs  in  W_RFADDR  pipeline rs read address
- rf_we  out  1  register file write enable
- rf_waddr  out  W_RFADDR  register file write address
- rf_wdata  out  W_DATA  register file write data
- rf_rs  out  W_RFADDR  register file rs read address
- rf_rdata  in  W_DATA  register file rfa output

Behaviour:
- Reset (asynchronous, from any state, mid-access included):
  - state = IDLE
  - cpu_halt = 0, dbg_ack = 0, dbg_rdata = 0, dbg_err = 0
  - drain counter = 0, captured request registers = 0
  - a pending debug access is abandoned with no register file write.
- States: IDLE, HALT, ACCESS, ACK, RELEASE, HELD. All are registered; cpu_halt is registered and equals (state != IDLE).
- IDLE:
  - dbg_req = 1 at a posedge captures dbg_we, dbg_addr and dbg_wdata, and loads the counter with DRAIN_CYCLES.
  - Next state is HALT, or ACCESS when DRAIN_CYCLES = 0.
- HALT:
  - Lasts exactly DRAIN_CYCLES cycles (counter decrements, exits at 1), then goes to ACCESS.
  - Pipeline writebacks pass through unchanged during HALT.
- ACCESS (one cycle):
  - rf_rs = captured address.
  - rf_we = captured we AND (address != 0); rf_waddr and rf_wdata come from the captured values.
  - On the posedge ending ACCESS, a read captures rf_rdata into dbg_rdata. A write leaves dbg_rdata unchanged.
  - Next state: ACK.
- ACK (one cycle): dbg_ack = 1. Next state: RELEASE.
- RELEASE:
  - Waits for dbg_req = 0.
  - Then goes to HELD if dbg_hold = 1, otherwise IDLE (cpu_halt drops the cycle after).
- HELD:
  - CPU stays halted.
  - dbg_req = 1 captures a new request and goes directly to ACCESS, with no drain.
  - dbg_hold = 0 with dbg_req = 0 goes to IDLE.
  - dbg_req = 1 takes priority over dbg_hold = 0.
- Total latency from req sampled in IDLE to ack: DRAIN_CYCLES + 2 cycles. From HELD: 2 cycles.
- Mux, all states except ACCESS: combinational pass-through.
  - rf_we = cpu_wb_we, rf_waddr = cpu_wb_addr, rf_wdata = cpu_wb_data, rf_rs = cpu_rs.
- Conflict: cpu_wb_we = 1 during ACCESS, ACK, RELEASE or HELD is a protocol violation.
  - dbg_err is set and stays set until rst.
  - In ACCESS the debug write wins and the pipeline write is dropped.
  - In ACK, RELEASE and HELD the pipeline write still passes through.
- Register 0:
  - A debug write to address 0 is dropped (rf_we = 0) but still acknowledged.
  - A debug read of address 0 returns 0, supplied by the register file.
- Changes on dbg_addr, dbg_wdata and dbg_we after capture are ignored.
- Debug requests are never preempted. cpu_halt has no effect on this block's own sequencing.

Test Plan:
- Debug write, DRAIN_CYCLES=3: req, we=1, addr=5, wdata=0xDEADBEEF at cycle 0.
  - Required: cpu_halt=1 over cycles 1..6; rf_we=1, rf_waddr=5 in cycle 4; dbg_ack in cycle 5; IDLE once req drops.
  - A following debug read of r5 returns dbg_rdata=0xDEADBEEF.
- Drain pass-through: cpu_wb_we=1, addr=7, data=0x12 during HALT.
  - Required: r7 written, dbg_err=0.
  - The same write injected during ACCESS of a debug write to r9: r9 written, r7 unchanged, dbg_err=1 and sticky.
- Register 0: debug write of 0xFFFFFFFF to r0 -> rf_we=0 in ACCESS, ack still issued; a subsequent read returns 0.
- Held burst: dbg_hold=1, three reads of r1..r3.
  - Required: a single drain; the second and third acks arrive 2 cycles after each req.
  - cpu_halt stays continuously 1 until hold=0 and req=0.
- Reset mid-access: assert rst in HALT with a pending write to r4.
  - Required: cpu_halt=0 immediately, no r4 write, dbg_ack never pulses, state IDLE.
- DRAIN_CYCLES=0: req read of r2 -> ACCESS in cycle 1, ack in cycle 2.

Source files
------------

// File: rtl/rf_dbg_arb.sv
// Register file port arbiter between the CPU pipeline and the debug monitor.
// A debug request halts the CPU, drains in-flight writebacks, then performs one
// debug register read or write and pulses an acknowledge.
module rf_dbg_arb #(
  parameter int W_DATA       = 32,
  parameter int W_RFADDR     = 5,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst,
  // debug monitor side
  input  logic                dbg_req,
  input  logic                dbg_we,
  input  logic [W_RFADDR-1:0] dbg_addr,
  input  logic [W_DATA-1:0]   dbg_wdata,
  input  logic                dbg_hold,
  output logic                dbg_ack,
  output logic [W_DATA-1:0]   dbg_rdata,
  output logic                dbg_err,
  // pipeline side
  output logic                cpu_halt,
  input  logic                cpu_wb_we,
  input  logic [W_RFADDR-1:0] cpu_wb_addr,
  input  logic [W_DATA-1:0]   cpu_wb_data,
  input  logic [W_RFADDR-1:0] cpu_rs,
  // register file side
  output logic                rf_we,
  output logic [W_RFADDR-1:0] rf_waddr,
  output logic [W_DATA-1:0]   rf_wdata,
  output logic [W_RFADDR-1:0] rf_rs,
  input  logic [W_DATA-1:0]   rf_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ACCESS,
    S_ACK,
    S_RELEASE,
    S_HELD
  } state_e;

  localparam logic [3:0] DRAIN = 4'(DRAIN_CYCLES);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                capture;
  logic                we_q;
  logic [W_RFADDR-1:0] addr_q;
  logic [W_DATA-1:0]   wdata_q;
  logic [W_DATA-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                halt_q, ack_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      halt_q  <= (state_d != S_IDLE);
      ack_q   <= (state_d == S_ACK);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (dbg_req) begin
          capture = 1'b1;
          cnt_d   = DRAIN;
          state_d = (DRAIN == 4'd0) ? S_ACCESS : S_HALT;
        end
      end
      S_HALT: begin
        // Exit on 1 so HALT lasts exactly DRAIN cycles after the load.
        if (cnt_q <= 4'd1) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACCESS: state_d = S_ACK;
      S_ACK:    state_d = S_RELEASE;
      S_RELEASE: begin
        if (!dbg_req) begin
          state_d = dbg_hold ? S_HELD : S_IDLE;
        end
      end
      S_HELD: begin
        // A new request beats a dropped hold; the pipeline is already drained.
        if (dbg_req) begin
          capture = 1'b1;
          state_d = S_ACCESS;
        end else if (!dbg_hold) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: register file port mux
  // ---------------------------------------------------------------------------
  always_comb begin
    rf_we    = cpu_wb_we;
    rf_waddr = cpu_wb_addr;
    rf_wdata = cpu_wb_data;
    rf_rs    = cpu_rs;
    if (state_q == S_ACCESS) begin
      // Register 0 is hardwired; a debug write to it is dropped but still acked.
      rf_we    = we_q && (addr_q != '0);
      rf_waddr = addr_q;
      rf_wdata = wdata_q;
      rf_rs    = addr_q;
    end
  end

  assign cpu_halt  = halt_q;
  assign dbg_ack   = ack_q;
  assign dbg_rdata = rdata_q;
  assign dbg_err   = err_q;

  // ---------------------------------------------------------------------------
  // Captured request, read result and sticky error
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata_d = rdata_q;
    if (state_q == S_ACCESS && !we_q) begin
      rdata_d = rf_rdata;
    end
    err_d = err_q;
    if (cpu_wb_we && (state_q == S_ACCESS || state_q == S_ACK ||
                      state_q == S_RELEASE || state_q == S_HELD)) begin
      err_d = 1'b1;
    end
  end

  // NOTE: these are a handful of control/data flops, not a memory array, so
  // all of them are reset to keep the post-reset state fully defined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (capture) begin
        we_q    <= dbg_we;
        addr_q  <= dbg_addr;
        wdata_q <= dbg_wdata;
      end
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_rf_dbg_arb.sv
// Directed self-checking bench for rf_dbg_arb: a DRAIN_CYCLES=3 instance with a
// register file model, plus a DRAIN_CYCLES=0 instance for the no-drain path.
module tb_rf_dbg_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        dbg_req, dbg_we, dbg_hold;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack, dbg_err, cpu_halt;
  logic [31:0] dbg_rdata;
  logic        cpu_wb_we;
  logic [4:0]  cpu_wb_addr, cpu_rs;
  logic [31:0] cpu_wb_data;
  logic        rf_we;
  logic [4:0]  rf_waddr, rf_rs;
  logic [31:0] rf_wdata, rf_rdata;

  logic        req0, ack0, err0, halt0, rf_we0;
  logic [4:0]  rs_in0, rf_waddr0, rf_rs0, addr0;
  logic [31:0] rdata0, rf_wdata0, rf_rdata0;

  logic [31:0] regs [32];

  int n_checks = 0;
  int n_errors = 0;
  int last_lat, last_acc, halt_gaps;

  always #5 clk = ~clk;

  rf_dbg_arb #(.W_DATA(32), .W_RFADDR(5), .DRAIN_CYCLES(3)) u_dut (
    .clk(clk), .rst(rst),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_hold(dbg_hold), .dbg_ack(dbg_ack),
    .dbg_rdata(dbg_rdata), .dbg_err(dbg_err), .cpu_halt(cpu_halt),
    .cpu_wb_we(cpu_wb_we), .cpu_wb_addr(cpu_wb_addr), .cpu_wb_data(cpu_wb_data),
    .cpu_rs(cpu_rs), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_rs(rf_rs), .rf_rdata(rf_rdata)
  );

  rf_dbg_arb #(.W_DATA(32), .W_RFADDR(5), .DRAIN_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .dbg_req(req0), .dbg_we(1'b0), .dbg_addr(addr0),
    .dbg_wdata(32'h0), .dbg_hold(1'b0), .dbg_ack(ack0),
    .dbg_rdata(rdata0), .dbg_err(err0), .cpu_halt(halt0),
    .cpu_wb_we(1'b0), .cpu_wb_addr(5'd0), .cpu_wb_data(32'h0),
    .cpu_rs(rs_in0), .rf_we(rf_we0), .rf_waddr(rf_waddr0), .rf_wdata(rf_wdata0),
    .rf_rs(rf_rs0), .rf_rdata(rf_rdata0)
  );

  // Register file model: r0 reads as zero, synchronous write.
  assign rf_rdata  = regs[rf_rs];
  assign rf_rdata0 = 32'hCAFE_0000 | {27'd0, rf_rs0};

  always @(posedge clk) begin
    if (rf_we && rf_waddr != 5'd0) regs[rf_waddr] <= rf_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One debug transaction; req is raised in the current cycle (cycle 0).
  task automatic dbg_txn(input logic we, input logic [4:0] addr,
                         input logic [31:0] wd, input logic hold);
    dbg_req   = 1'b1;
    dbg_we    = we;
    dbg_addr  = addr;
    dbg_wdata = wd;
    dbg_hold  = hold;
    last_lat  = -1;
    last_acc  = -1;
    tick();
    dbg_we    = ~we;
    dbg_addr  = ~addr;
    dbg_wdata = ~wd;
    for (int i = 1; i <= 40; i++) begin
      #4;
      if (!cpu_halt) halt_gaps++;
      if (rf_we && !cpu_wb_we && last_acc < 0) last_acc = i;
      if (dbg_ack) last_lat = i;
      tick();
      if (last_lat >= 0) break;
    end
    dbg_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + i;
    rst = 1'b1;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_hold = 0;
    cpu_wb_we = 0; cpu_wb_addr = 0; cpu_wb_data = 0; cpu_rs = 5'd6;
    req0 = 0; addr0 = 0; rs_in0 = 5'd17;
    halt_gaps = 0;
    repeat (2) tick();
    rst = 1'b0;
    #4;
    check("rst_halt", {31'd0, cpu_halt}, 32'd0);
    check("rst_ack", {31'd0, dbg_ack}, 32'd0);
    check("rst_rdata", dbg_rdata, 32'd0);
    check("rst_err", {31'd0, dbg_err}, 32'd0);
    check("rst_pass_rs", {27'd0, rf_rs}, 32'd6);
    tick();

    // Debug write r5 with drain of 3
    dbg_txn(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
    check("wr5_lat", last_lat, 32'd5);
    check("wr5_access_cycle", last_acc, 32'd4);
    check("wr5_halt_gaps", halt_gaps, 32'd0);
    check("wr5_regfile", regs[5], 32'hDEAD_BEEF);
    #4;
    check("wr5_release_halt", {31'd0, cpu_halt}, 32'd1);
    tick();
    #4;
    check("wr5_idle_halt", {31'd0, cpu_halt}, 32'd0);
    tick();

    dbg_txn(1'b0, 5'd5, 32'h0, 1'b0);
    check("rd5_lat", last_lat, 32'd5);
    check("rd5_rdata", dbg_rdata, 32'hDEAD_BEEF);
    tick();

    // Pipeline writeback during HALT passes through cleanly
    fork
      dbg_txn(1'b0, 5'd1, 32'h0, 1'b0);
      begin
        tick();
        cpu_wb_we = 1; cpu_wb_addr = 5'd7; cpu_wb_data = 32'h12;
        tick();
        cpu_wb_we = 0;
      end
    join
    check("drain_r7", regs[7], 32'h12);
    check("drain_err", {31'd0, dbg_err}, 32'd0);
    check("rd1_rdata", dbg_rdata, 32'h1000_0001);
    tick();

    // Pipeline writeback colliding with a debug write in ACCESS
    fork
      dbg_txn(1'b1, 5'd9, 32'h9999_0009, 1'b0);
      begin
        repeat (4) tick();
        cpu_wb_we = 1; cpu_wb_addr = 5'd7; cpu_wb_data = 32'h55;
        tick();
        cpu_wb_we = 0;
      end
    join
    check("conf_r9", regs[9], 32'h9999_0009);
    check("conf_r7", regs[7], 32'h12);
    check("conf_err", {31'd0, dbg_err}, 32'd1);
    tick();

    // Register 0: write dropped but acked; read returns 0
    dbg_txn(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
    check("r0_wr_lat", last_lat, 32'd5);
    check("r0_wr_no_we", last_acc, 32'hFFFF_FFFF);
    tick();
    dbg_txn(1'b0, 5'd0, 32'h0, 1'b0);
    check("r0_rdata", dbg_rdata, 32'd0);
    check("err_sticky", {31'd0, dbg_err}, 32'd1);
    tick();

    // Held burst of three reads with a single drain
    halt_gaps = 0;
    dbg_txn(1'b0, 5'd1, 32'h0, 1'b1);
    check("burst1_lat", last_lat, 32'd5);
    check("burst1_rdata", dbg_rdata, 32'h1000_0001);
    tick();
    #4;
    check("held_halt", {31'd0, cpu_halt}, 32'd1);
    tick();
    dbg_txn(1'b0, 5'd2, 32'h0, 1'b1);
    check("burst2_lat", last_lat, 32'd2);
    check("burst2_rdata", dbg_rdata, 32'h1000_0002);
    tick();
    dbg_txn(1'b0, 5'd3, 32'h0, 1'b1);
    check("burst3_lat", last_lat, 32'd2);
    check("burst3_rdata", dbg_rdata, 32'h1000_0003);
    tick();
    check("burst_halt_gaps", halt_gaps, 32'd0);
    dbg_hold = 1'b0;
    #4;
    check("unhold_halt", {31'd0, cpu_halt}, 32'd1);
    tick();
    #4;
    check("unhold_idle", {31'd0, cpu_halt}, 32'd0);
    tick();

    // Reset while a write to r4 is draining
    dbg_req = 1; dbg_we = 1; dbg_addr = 5'd4; dbg_wdata = 32'h4444_4444;
    tick();
    #4;
    check("prerst_halt", {31'd0, cpu_halt}, 32'd1);
    #1;
    rst = 1'b1;
    dbg_req = 1'b0;
    #1;
    check("midrst_halt", {31'd0, cpu_halt}, 32'd0);
    check("midrst_err", {31'd0, dbg_err}, 32'd0);
    check("midrst_rdata", dbg_rdata, 32'd0);
    tick();
    rst = 1'b0;
    begin
      logic saw_ack, saw_halt;
      saw_ack = 0; saw_halt = 0;
      for (int i = 0; i < 8; i++) begin
        #4;
        if (dbg_ack) saw_ack = 1;
        if (cpu_halt) saw_halt = 1;
        tick();
      end
      check("postrst_no_ack", {31'd0, saw_ack}, 32'd0);
      check("postrst_idle", {31'd0, saw_halt}, 32'd0);
    end
    check("postrst_r4", regs[4], 32'h1000_0004);
    cpu_rs = 5'd11;
    #4;
    check("postrst_pass_rs", {27'd0, rf_rs}, 32'd11);
    tick();
    dbg_txn(1'b0, 5'd4, 32'h0, 1'b0);
    check("postrst_rd4_lat", last_lat, 32'd5);
    check("postrst_rd4", dbg_rdata, 32'h1000_0004);
    tick();

    // DRAIN_CYCLES = 0 instance: read r2
    req0 = 1'b1; addr0 = 5'd2;
    #4;
    check("d0_c0_rs", {27'd0, rf_rs0}, 32'd17);
    check("d0_c0_halt", {31'd0, halt0}, 32'd0);
    tick();
    addr0 = 5'd9;
    #4;
    check("d0_c1_rs", {27'd0, rf_rs0}, 32'd2);
    check("d0_c1_halt", {31'd0, halt0}, 32'd1);
    check("d0_c1_ack", {31'd0, ack0}, 32'd0);
    check("d0_c1_we", {31'd0, rf_we0}, 32'd0);
    tick();
    #4;
    check("d0_c2_ack", {31'd0, ack0}, 32'd1);
    check("d0_rdata", rdata0, 32'hCAFE_0002);
    tick();
    req0 = 1'b0;
    #4;
    check("d0_release_halt", {31'd0, halt0}, 32'd1);
    tick();
    #4;
    check("d0_idle_halt", {31'd0, halt0}, 32'd0);
    check("d0_err", {31'd0, err0}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
